// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO, runtime divisor, parity and stop-bit selection.
// Frames are sent back-to-back whenever the FIFO still holds data at the end of a frame.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line idle, waiting for the FIFO to hold a word
// S_START  | driving the start bit (0) for one bit period
// S_DATA   | shifting DATA_BITS data bits out, LSB first
// S_PARITY | driving the even/odd parity bit for one bit period
// S_STOP   | driving one or two stop bits (1); may chain straight into S_START
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop2,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int                AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;

    // Per-frame settings, captured when a word is popped
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q;
    logic                 par_en_q;
    logic                 stop2_q;
    logic [DIV_W-1:0]     div_q;

    // Bit timing
    logic [DIV_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic                 bit_end, last_data, last_stop;

    logic                 tx_nxt, done_nxt;

    assign in_ready   = (fifo_count != CNT_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_count == '0);
    assign head       = mem[rd_ptr];

    assign bit_end    = (baud_cnt == div_q - 1'b1);
    assign last_data  = (bit_cnt == LAST_DATA);
    assign last_stop  = (bit_cnt == {3'b000, stop2_q});

    assign busy       = (state != S_IDLE) || !fifo_empty;

    // FIFO storage write; contents need no reset since the pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && last_data) begin
                    state_nxt = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end && last_stop) begin
                    state_nxt = fifo_empty ? S_IDLE : S_START;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: pop request, next line level and end-of-frame strobe
    always_comb begin
        pop      = 1'b0;
        tx_nxt   = 1'b1;
        done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                pop = !fifo_empty;
            end
            S_START: begin
                tx_nxt = 1'b0;
            end
            S_DATA: begin
                tx_nxt = shift_q[0];
            end
            S_PARITY: begin
                tx_nxt = par_bit_q;
            end
            S_STOP: begin
                if (bit_end && last_stop) begin
                    done_nxt = 1'b1;
                    pop      = !fifo_empty;
                end
            end
            default: begin
                tx_nxt = 1'b1;
            end
        endcase
    end

    // Frame datapath: load a popped word with its settings, then time and shift bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= DIV_MIN;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else if (pop) begin
            shift_q   <= head;
            par_bit_q <= (^head) ^ (parity_mode == 2'd2);
            par_en_q  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
            stop2_q   <= stop2;
            div_q     <= (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else if (state != S_IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (state == S_DATA) begin
                    shift_q <= shift_q >> 1;
                end
                bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 1'b1;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Registered line and done strobe; both trail the FSM state by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_nxt;
            tx_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues the expected frames,
// a monitor decodes the tx line every clock and compares against the queue.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic [2:0]  fifo_count;

    uart_tx_fifo #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame: data byte, clocks per bit, parity bit (-1 = none),
    // stop-bit count, and whether it must start right after the previous frame.
    typedef struct {
        logic [7:0] data;
        int         div;
        int         par;
        int         nstop;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    bit   in_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: decode frames from tx and compare every clock of every bit
    initial begin : monitor
        exp_t  e;
        logic  bits[$];
        bit    chain, unexp, aborted, bad, done_bad;
        logic  bad_val;
        chain = 1'b0;
        unexp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                chain = 1'b0;
                unexp = 1'b0;
                continue;
            end
            if (tx_done === 1'b1) check("stray tx_done", 1, 0);
            if (tx !== 1'b0) begin
                if (chain) check("back-to-back start tx", tx, 0);
                chain = 1'b0;
                unexp = 1'b0;
                continue;
            end
            chain = 1'b0;
            if (exp_q.size() == 0) begin
                if (!unexp) check("unexpected frame start", 1, 0);
                unexp = 1'b1;
                continue;
            end
            e = exp_q.pop_front();
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(e.data[i]);
            if (e.par >= 0) bits.push_back(e.par[0]);
            for (int s = 0; s < e.nstop; s++) bits.push_back(1'b1);
            in_frame = 1'b1;
            aborted  = 1'b0;
            done_bad = 1'b0;
            for (int b = 0; b < bits.size() && !aborted; b++) begin
                bad     = 1'b0;
                bad_val = bits[b];
                for (int c = 0; c < e.div; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== bits[b] && !bad) begin
                        bad     = 1'b1;
                        bad_val = tx;
                    end
                    if (tx_done !== ((b == bits.size() - 1) && (c == e.div - 1))) done_bad = 1'b1;
                end
                if (!aborted) check($sformatf("frame %02h bit %0d tx", e.data, b), bad_val, bits[b]);
            end
            in_frame = 1'b0;
            if (aborted) begin
                exp_q.delete();
                continue;
            end
            check($sformatf("frame %02h tx_done timing error", e.data), done_bad, 0);
            if (exp_q.size() > 0 && exp_q[0].b2b) chain = 1'b1;
        end
    end

    // Queue one word; called and returns at 1 time unit after a rising edge
    task automatic write(input logic [7:0] d, input int div, input int par,
                         input int nstop, input bit b2b);
        int guard;
        exp_t e;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) begin
            check("in_ready wait timeout", 0, 1);
        end else begin
            e.data  = d;
            e.div   = div;
            e.par   = par;
            e.nstop = nstop;
            e.b2b   = b2b;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || in_frame) && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) check("idle wait timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        n_tests     = 0;
        n_fail      = 0;
        in_frame    = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        baud_div    = 16'd4;
        parity_mode = 2'd0;
        stop2       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", tx, 1);
        check("reset in_ready", in_ready, 1);
        check("reset busy", busy, 0);
        check("reset tx_done", tx_done, 0);
        check("reset fifo_count", fifo_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8N1, divisor 4, with start-bit latency
        write(8'hA5, 4, -1, 1, 1'b0);
        check("fifo_count after write", fifo_count, 1);
        @(posedge clk);
        #1;
        check("tx one clock after write", tx, 1);
        check("fifo_count after pop", fifo_count, 0);
        check("busy during frame", busy, 1);
        @(posedge clk);
        #1;
        check("tx two clocks after write", tx, 0);
        wait_idle();

        // Even then odd parity on 0x07
        parity_mode = 2'd1;
        write(8'h07, 4, 1, 1, 1'b0);
        wait_idle();
        parity_mode = 2'd2;
        write(8'h07, 4, 0, 1, 1'b0);
        wait_idle();

        // Two stop bits, back-to-back frames
        parity_mode = 2'd0;
        stop2       = 1'b1;
        write(8'h00, 4, -1, 2, 1'b0);
        write(8'hFF, 4, -1, 2, 1'b1);
        wait_idle();
        stop2 = 1'b0;

        // FIFO fill: one word in flight, four queued, sixth waits
        baud_div = 16'd10;
        write(8'h11, 10, -1, 1, 1'b0);
        write(8'h22, 10, -1, 1, 1'b1);
        write(8'h33, 10, -1, 1, 1'b1);
        write(8'h44, 10, -1, 1, 1'b1);
        write(8'h55, 10, -1, 1, 1'b1);
        check("fifo_count when full", fifo_count, 4);
        check("in_ready when full", in_ready, 0);
        write(8'h66, 10, -1, 1, 1'b1);
        wait_idle();

        // Divisor clamp
        baud_div = 16'd1;
        write(8'h3C, 2, -1, 1, 1'b0);
        wait_idle();
        baud_div = 16'd0;
        write(8'hC3, 2, -1, 1, 1'b0);
        wait_idle();

        // Divisor change mid-frame only affects the next frame
        baud_div = 16'd4;
        write(8'h5A, 4, -1, 1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        baud_div = 16'd8;
        write(8'h96, 8, -1, 1, 1'b1);
        wait_idle();

        // Reset during the data bits of the second of three queued words
        baud_div = 16'd4;
        write(8'h81, 4, -1, 1, 1'b0);
        write(8'h42, 4, -1, 1, 1'b1);
        write(8'h24, 4, -1, 1, 1'b1);
        repeat (53) @(posedge clk);
        #1;
        check("tx low before reset", tx, 0);
        check("fifo_count before reset", fifo_count, 1);
        rst_n = 1'b0;
        #1;
        check("tx after async reset", tx, 1);
        check("fifo_count after async reset", fifo_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("in_ready after reset release", in_ready, 1);
        check("busy after reset release", busy, 0);
        check("tx after reset release", tx, 1);
        check("fifo_count after reset release", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
